bcd_registrador_n: RTL and testbench
====================================

Name: bcd_registrador_n

Overview:
- Parametrised multi-digit BCD register bank.
- Successor to the single-digit BCD register.
- Holds NDIG packed BCD digits.
- Supports sync clear, parallel load, keypad-style digit shift-in, and backspace, with digit-count tracking and error flagging.
- Sits between keypad/entry logic and the BCD display/arithmetic datapath.

Parameters:
- NDIG, 4, number of BCD digits stored (≥2).
- CW, $clog2(NDIG+1), width of digit-count output (derived; not overridden).

Ports:
- ck  in  1  clock; all state updates on falling edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear.
- ld  in  1  parallel load of d.
- d  in  4*NDIG  parallel data; digit 0 = bits [3:0] (least significant).
- sh  in  1  shift in digit din at LSD; existing digits move one place toward MSD.
- din  in  4  digit to shift in.
- del  in  1  backspace; digits move one place toward LSD, 0 enters MSD.
- q  out  4*NDIG  stored digits.
- cnt  out  CW  count of significant digits entered (0..NDIG).
- full  out  1  cnt == NDIG.
- empty  out  1  cnt == 0.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): q=0, cnt=0, err=0. Reset mid-operation discards any command in flight.
- All other updates occur at negedge ck. Outputs are registered with 1-edge latency; full and empty decode cnt combinationally.
- Command priority when several are asserted: clr > ld > sh > del (> inc if enabled). Lower-priority commands in the same edge are ignored without error.
- clr: q=0, cnt=0, err=0.
- ld:
  - Each digit of d >9 is replaced by 0, and err=1 for that edge.
  - cnt = index of most-significant nonzero stored digit + 1, or 0 if all zero.
- sh, din ≤9, not full: q = {q[4*NDIG-5:0], din}; cnt+1.
  - Exception: a leading zero is not counted. If cnt==0 and din==0, q and cnt stay 0.
- sh, din >9: q and cnt unchanged, err=1.
- sh when full: q and cnt unchanged, err=1. No wrap, MSD never lost.
- del, not empty: q = {4'h0, q[4*NDIG-1:4]}; cnt-1.
- del when empty: no change, err=1.
- No command: q and cnt hold; err=0.
- err is high for exactly the edge-cycle following the offending command, then clears automatically.
- Invariant: all digits above position cnt-1 are 0 at all times.

Optional Feature:
- Macro: BCD_REGISTRADOR_INC_EN.
- When defined:
  - Adds input inc (1) and output ovf (1, reset 0).
  - inc has lowest priority. It adds 1 to the value in q in BCD, with decimal carry rippling across all digits.
  - 9→0 with carry into the next digit.
  - All-9s wraps to all-0 with ovf=1 for one cycle and cnt=0.
  - Otherwise cnt is recomputed as on ld.
- When undefined: the inc/ovf ports and the increment logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4, BCD_MAX=4'd9.
  - Enum cmd_t {CMD_NONE, CMD_CLR, CMD_LD, CMD_SH, CMD_DEL, CMD_INC}, produced by a priority-encode function.
  - Function bcd_valid(digit).
- Sub-module bcd_inc_digit: one-digit BCD incrementer, inputs digit and cin, outputs digit and cout. Instantiated NDIG times in a generate chain, only under BCD_REGISTRADOR_INC_EN.

Test Plan:
- Reset then idle: rst_n 0→1 → q=0, cnt=0, empty=1, full=0, err=0. Assert rst_n=0 mid-shift → q clears immediately without a clock edge.
- Entry, NDIG=4: sh din=1,2,3,4 → q=16'h1234, cnt=4, full=1. Then sh din=5 → q stays 16'h1234, err pulses 1 cycle.
- Leading zero and invalid digit: from empty, sh din=0 → q=0, cnt=0. Then sh din=4'hA → err=1, q unchanged. Then sh din=7 → q=16'h0007, cnt=1.
- Backspace: q=16'h0123 (cnt=3), del ×3 → 16'h0012, 16'h0001, 16'h0000, cnt=0. A 4th del → err=1.
- Load and priority: ld d=16'h0A50 → q=16'h0050, cnt=2, err=1. Same edge clr+ld+sh → q=0, cnt=0, err=0.
- INC (BCD_REGISTRADOR_INC_EN defined):
  - q=16'h0199, inc → 16'h0200, cnt=3.
  - q=16'h9999, inc → q=0, ovf=1 one cycle, cnt=0.

Source files
------------

// File: rtl/bcd_registrador_n_pkg.sv
// Shared definitions for the multi-digit BCD register bank.
// Holds the digit width, the largest legal digit, the command encoding,
// the priority encoder that turns the raw strobes into one command, and
// a digit-validity helper.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_CLR  = 3'd1,
    CMD_LD   = 3'd2,
    CMD_SH   = 3'd3,
    CMD_DEL  = 3'd4,
    CMD_INC  = 3'd5
  } cmd_t;

  // Resolve simultaneous strobes: clr > ld > sh > del > inc.
  function automatic cmd_t cmd_encode(input logic clr, input logic ld,
                                      input logic sh, input logic del,
                                      input logic inc);
    cmd_t c;
    if (clr) begin
      c = CMD_CLR;
    end else if (ld) begin
      c = CMD_LD;
    end else if (sh) begin
      c = CMD_SH;
    end else if (del) begin
      c = CMD_DEL;
    end else if (inc) begin
      c = CMD_INC;
    end else begin
      c = CMD_NONE;
    end
    return c;
  endfunction

  // A nibble is a legal BCD digit when it does not exceed 9.
  function automatic logic bcd_valid(input logic [3:0] digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_registrador_n_inc_digit.sv
// One-digit BCD incrementer: adds cin to a legal digit, producing the
// result digit and a decimal carry out (9 + 1 -> 0 with carry).
module bcd_inc_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       cin,
  output logic [3:0] dout,
  output logic       cout
);

  // Decimal add of the carry bit to one digit.
  always_comb begin
    dout = digit;
    cout = 1'b0;
    if (cin) begin
      if (digit >= BCD_MAX) begin
        dout = 4'd0;
        cout = 1'b1;
      end else begin
        dout = digit + 4'd1;
        cout = 1'b0;
      end
    end else begin
      dout = digit;
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_registrador_n.sv
// Multi-digit packed BCD register bank for keypad-style entry.
// Supports clear, parallel load, shift-in at the least significant digit,
// backspace, and tracks how many significant digits are held.
// All state changes on the falling edge of ck; rst_n is asynchronous.
// Optional macro BCD_REGISTRADOR_INC_EN adds a decimal increment command
// (input inc) with an overflow pulse (output ovf).
module bcd_registrador_n
  import bcd_pkg::*;
#(
  parameter  int NDIG = 4,
  localparam int CW   = $clog2(NDIG + 1)
) (
  input  logic              ck,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [4*NDIG-1:0] d,
  input  logic              sh,
  input  logic [3:0]        din,
  input  logic              del,
`ifdef BCD_REGISTRADOR_INC_EN
  input  logic              inc,
  output logic              ovf,
`endif
  output logic [4*NDIG-1:0] q,
  output logic [CW-1:0]     cnt,
  output logic              full,
  output logic              empty,
  output logic              err
);

  localparam logic [CW-1:0] CNT_FULL = CW'(NDIG);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [4*NDIG-1:0] q_r;
  logic [CW-1:0]     cnt_r;
  logic              err_r;

  logic [4*NDIG-1:0] q_nxt_s;
  logic [CW-1:0]     cnt_nxt_s;
  logic              err_nxt_s;

  logic [4*NDIG-1:0] ld_q_s;
  logic              ld_bad_s;
  logic              inc_req_s;
  cmd_t              cmd_s;

  // Number of significant digits: position of the highest nonzero digit + 1.
  function automatic logic [CW-1:0] sig_count(input logic [4*NDIG-1:0] v);
    logic [CW-1:0] c;
    c = CNT_ZERO;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] != 4'd0) begin
        c = CW'(i + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

`ifdef BCD_REGISTRADOR_INC_EN
  logic              ovf_r;
  logic              ovf_nxt_s;
  logic [NDIG:0]     carry_s;
  logic [4*NDIG-1:0] inc_q_s;

  assign inc_req_s  = inc;
  assign carry_s[0] = 1'b1;

  for (genvar g = 0; g < NDIG; g++) begin : g_inc
    bcd_inc_digit u_dig (
      .digit (q_r[4*g +: 4]),
      .cin   (carry_s[g]),
      .dout  (inc_q_s[4*g +: 4]),
      .cout  (carry_s[g+1])
    );
  end

  assign ovf = ovf_r;
`else
  assign inc_req_s = 1'b0;
`endif

  assign cmd_s = cmd_encode(clr, ld, sh, del, inc_req_s);

  // Sanitise parallel-load data: illegal digits become 0 and flag an error.
  always_comb begin
    ld_q_s   = '0;
    ld_bad_s = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_valid(d[4*i +: 4])) begin
        ld_q_s[4*i +: 4] = d[4*i +: 4];
      end else begin
        ld_q_s[4*i +: 4] = 4'd0;
        ld_bad_s         = 1'b1;
      end
    end
  end

  // Next-state selection for the digits, count and status pulses.
  always_comb begin
    q_nxt_s   = q_r;
    cnt_nxt_s = cnt_r;
    err_nxt_s = 1'b0;
`ifdef BCD_REGISTRADOR_INC_EN
    ovf_nxt_s = 1'b0;
`endif
    case (cmd_s)
      CMD_CLR: begin
        q_nxt_s   = '0;
        cnt_nxt_s = CNT_ZERO;
      end
      CMD_LD: begin
        q_nxt_s   = ld_q_s;
        cnt_nxt_s = sig_count(ld_q_s);
        err_nxt_s = ld_bad_s;
      end
      CMD_SH: begin
        if (!bcd_valid(din)) begin
          err_nxt_s = 1'b1;
        end else if (cnt_r == CNT_FULL) begin
          // Refuse rather than lose the most significant digit.
          err_nxt_s = 1'b1;
        end else if ((cnt_r == CNT_ZERO) && (din == 4'd0)) begin
          // Leading zero: nothing significant to record.
          q_nxt_s   = q_r;
        end else begin
          q_nxt_s   = {q_r[4*NDIG-5:0], din};
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      CMD_DEL: begin
        if (cnt_r == CNT_ZERO) begin
          err_nxt_s = 1'b1;
        end else begin
          q_nxt_s   = {4'h0, q_r[4*NDIG-1:4]};
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      CMD_INC: begin
`ifdef BCD_REGISTRADOR_INC_EN
        q_nxt_s = inc_q_s;
        if (carry_s[NDIG]) begin
          ovf_nxt_s = 1'b1;
          cnt_nxt_s = CNT_ZERO;
        end else begin
          cnt_nxt_s = sig_count(inc_q_s);
        end
`else
        q_nxt_s = q_r;
`endif
      end
      default: begin
        q_nxt_s   = q_r;
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // State register, updated on the falling clock edge.
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= '0;
      cnt_r <= CNT_ZERO;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      cnt_r <= cnt_nxt_s;
      err_r <= err_nxt_s;
    end
  end

`ifdef BCD_REGISTRADOR_INC_EN
  // Overflow pulse register, one cycle after an all-nines increment.
  always_ff @(negedge ck or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_nxt_s;
    end
  end
`endif

  assign q     = q_r;
  assign cnt   = cnt_r;
  assign err   = err_r;
  assign full  = (cnt_r == CNT_FULL);
  assign empty = (cnt_r == CNT_ZERO);

endmodule

// File: tb/tb_bcd_registrador_n.sv
// Self-checking bench for bcd_registrador_n. The reference model keeps the
// register contents as a plain decimal integer; digit count is the number
// of decimal digits of that integer.
module tb_bcd_registrador_n;

  localparam int NDIG = 4;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int VMAX = 10000;

  logic              ck = 1'b0;
  logic              rst_n;
  logic              clr, ld, sh, del;
  logic [4*NDIG-1:0] d;
  logic [3:0]        din;
  logic [4*NDIG-1:0] q;
  logic [CW-1:0]     cnt;
  logic              full, empty, err;
  logic              inc;
`ifdef BCD_REGISTRADOR_INC_EN
  logic              ovf;
`endif

  int unsigned m_val;
  bit          m_err, m_ovf;
  int          total, passed;

  bcd_registrador_n #(.NDIG(NDIG)) dut (
    .ck    (ck),
    .rst_n (rst_n),
    .clr   (clr),
    .ld    (ld),
    .d     (d),
    .sh    (sh),
    .din   (din),
    .del   (del),
`ifdef BCD_REGISTRADOR_INC_EN
    .inc   (inc),
    .ovf   (ovf),
`endif
    .q     (q),
    .cnt   (cnt),
    .full  (full),
    .empty (empty),
    .err   (err)
  );

  always #5 ck = ~ck;

  function automatic int ndigits(input int unsigned v);
    int n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic logic [4*NDIG-1:0] to_bcd(input int unsigned v);
    logic [4*NDIG-1:0] r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".q"}, 32'(q), 32'(to_bcd(m_val)));
    check_eq({tag, ".cnt"}, 32'(cnt), 32'(ndigits(m_val)));
    check_eq({tag, ".full"}, 32'(full), 32'(ndigits(m_val) == NDIG));
    check_eq({tag, ".empty"}, 32'(empty), 32'(m_val == 0));
    check_eq({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef BCD_REGISTRADOR_INC_EN
    check_eq({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
`endif
  endtask

  // Reference behaviour for one clock edge, in decimal arithmetic.
  task automatic model_apply(input bit c, input bit l, input logic [15:0] dv,
                             input bit s, input logic [3:0] di, input bit de, input bit in);
    m_err = 1'b0;
    m_ovf = 1'b0;
    if (c) begin
      m_val = 0;
    end else if (l) begin
      int unsigned pw = 1;
      m_val = 0;
      for (int i = 0; i < NDIG; i++) begin
        int unsigned dg = int'(dv[4*i +: 4]);
        if (dg > 9) begin
          dg = 0;
          m_err = 1'b1;
        end
        m_val += dg * pw;
        pw *= 10;
      end
    end else if (s) begin
      if (di > 4'd9) m_err = 1'b1;
      else if (ndigits(m_val) == NDIG) m_err = 1'b1;
      else m_val = m_val * 10 + int'(di);
    end else if (de) begin
      if (m_val == 0) m_err = 1'b1;
      else m_val = m_val / 10;
    end else if (in) begin
      if (m_val == VMAX - 1) begin
        m_val = 0;
        m_ovf = 1'b1;
      end else begin
        m_val = m_val + 1;
      end
    end
  endtask

  task automatic step(input string tag, input bit c, input bit l, input logic [15:0] dv,
                      input bit s, input logic [3:0] di, input bit de, input bit in);
    clr = c; ld = l; d = dv; sh = s; din = di; del = de; inc = in;
    model_apply(c, l, dv, s, di, de, in);
    @(negedge ck);
    @(posedge ck);
    check_all(tag);
  endtask

  initial begin
    total = 0; passed = 0;
    m_val = 0; m_err = 1'b0; m_ovf = 1'b0;
    rst_n = 1'b0;
    clr = 1'b0; ld = 1'b0; d = '0; sh = 1'b0; din = 4'd0; del = 1'b0; inc = 1'b0;
    repeat (2) @(posedge ck);
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 0, 0, 16'h0, 0, 4'd0, 0, 0);

    // Keypad entry up to full, then refused extra digit.
    for (int i = 1; i <= 4; i++) step("entry", 0, 0, 16'h0, 1, 4'(i), 0, 0);
    check_eq("entry.q1234", 32'(q), 32'h1234);
    step("sh_full", 0, 0, 16'h0, 1, 4'd5, 0, 0);
    step("err_clears", 0, 0, 16'h0, 0, 4'd0, 0, 0);

    // Leading zero and illegal digit.
    step("clr", 1, 0, 16'h0, 0, 4'd0, 0, 0);
    step("lead0", 0, 0, 16'h0, 1, 4'd0, 0, 0);
    step("sh_bad", 0, 0, 16'h0, 1, 4'hA, 0, 0);
    step("sh7", 0, 0, 16'h0, 1, 4'd7, 0, 0);
    check_eq("sh7.q", 32'(q), 32'h0007);

    // Backspace down to empty and one past it.
    step("ld0123", 0, 1, 16'h0123, 0, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) step("del", 0, 0, 16'h0, 0, 4'd0, 1, 0);

    // Load sanitising and command priority.
    step("ld_bad", 0, 1, 16'h0A50, 0, 4'd0, 0, 0);
    check_eq("ld_bad.q", 32'(q), 32'h0050);
    step("prio", 1, 1, 16'h0987, 1, 4'd3, 1, 0);
    step("ld_sh_prio", 0, 1, 16'h0042, 1, 4'hF, 1, 0);

`ifdef BCD_REGISTRADOR_INC_EN
    step("ld0199", 0, 1, 16'h0199, 0, 4'd0, 0, 0);
    step("inc0199", 0, 0, 16'h0, 0, 4'd0, 0, 1);
    check_eq("inc0199.q", 32'(q), 32'h0200);
    step("ld9999", 0, 1, 16'h9999, 0, 4'd0, 0, 0);
    step("inc9999", 0, 0, 16'h0, 0, 4'd0, 0, 1);
    step("ovf_clears", 0, 0, 16'h0, 0, 4'd0, 0, 0);
`endif

    // Asynchronous reset in the middle of a shift command.
    step("pre_rst", 0, 1, 16'h0012, 0, 4'd0, 0, 0);
    sh = 1'b1; din = 4'd3;
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst.q", 32'(q), 32'h0);
    check_eq("async_rst.cnt", 32'(cnt), 32'h0);
    sh = 1'b0; din = 4'd0;
    m_val = 0; m_err = 1'b0; m_ovf = 1'b0;
    @(negedge ck);
    @(posedge ck);
    check_all("in_rst");
    rst_n = 1'b1;

    // Randomised command mix, including overlapping strobes.
    for (int n = 0; n < 400; n++) begin
      bit c, l, s, de, in;
      c  = ($urandom_range(0, 29) == 0);
      l  = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 1) == 0);
      de = ($urandom_range(0, 2) == 0);
`ifdef BCD_REGISTRADOR_INC_EN
      in = ($urandom_range(0, 3) == 0);
`else
      in = 1'b0;
`endif
      step("rand", c, l, 16'($urandom), s, 4'($urandom_range(0, 11)), de, in);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
